// File: rtl/instruction_loader_if.sv
// Instruction loader bus: load control, byte stream handshake, memory write
// port and status.
//   master : load controller / byte source (drives start, abort, word_count,
//            in_data, in_valid)
//   slave  : instruction_loader
interface instruction_loader_if #(
  parameter int N  = 32,
  parameter int IM = 5
);
  logic          start;
  logic          abort;
  logic [IM:0]   word_count;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          mem_we;
  logic [IM-1:0] mem_addr;
  logic [N-1:0]  mem_wdata;
  logic          busy;
  logic          done;

  modport master (
    output start, abort, word_count, in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done
  );

  modport slave (
    input  start, abort, word_count, in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done
  );
endinterface

// File: rtl/instruction_loader.sv
// Instruction loader: assembles N-bit words from an MSB-first byte stream and
// writes them to consecutive instruction memory addresses starting at 0.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : instruction_loader_if.slave
//                start/word_count (0 or >2**IM means 2**IM words), abort,
//                in_data/in_valid/in_ready byte handshake,
//                mem_we/mem_addr/mem_wdata write port, busy, sticky done.
module instruction_loader #(
  parameter int N  = 32,
  parameter int IM = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instruction_loader_if.slave  bus
);
  localparam int NB = N / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BW-1:0] BLAST = BW'(NB - 1);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t        state;
  logic [IM-1:0] idx;    // word index, doubles as write address
  logic [IM-1:0] last;   // index of the final word, saturated at 2**IM-1
  logic [BW-1:0] bcnt;   // byte position within the current word
  logic [N-1:0]  word;   // assembly register, doubles as write data
  logic          rdy, we, bsy, dn;

  assign bus.in_ready  = rdy;
  assign bus.mem_addr  = idx;
  assign bus.mem_wdata = word;
  assign bus.busy      = bsy;
  assign bus.done      = dn;
  // The write strobe is registered, but an abort arriving during the WRITE
  // cycle itself must still kill that write, hence the late gating.
  assign bus.mem_we    = we & ~bus.abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      last  <= '0;
      bcnt  <= '0;
      word  <= '0;
      rdy   <= 1'b0;
      we    <= 1'b0;
      bsy   <= 1'b0;
      dn    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            // Storing the last index (count-1) keeps idx at IM bits and
            // makes 2**IM words end at the all-ones index without wrapping.
            if (bus.word_count == '0 || bus.word_count[IM]) last <= '1;
            else last <= bus.word_count[IM-1:0] - IM'(1);
            idx   <= '0;
            bcnt  <= '0;
            word  <= '0;
            dn    <= 1'b0;
            rdy   <= 1'b1;
            bsy   <= 1'b1;
            state <= RECV;
          end
        end
        RECV: begin
          if (bus.abort) begin
            // Abort wins over a byte offered in the same cycle.
            word  <= '0;
            bcnt  <= '0;
            rdy   <= 1'b0;
            bsy   <= 1'b0;
            state <= IDLE;
          end else if (bus.in_valid) begin
            word <= (word << 8) | N'(bus.in_data);
            if (bcnt == BLAST) begin
              bcnt  <= '0;
              rdy   <= 1'b0;
              we    <= 1'b1;
              state <= WRITE;
            end else begin
              bcnt <= bcnt + BW'(1);
            end
          end
        end
        WRITE: begin
          we <= 1'b0;
          if (bus.abort) begin
            word  <= '0;
            bsy   <= 1'b0;
            state <= IDLE;
          end else if (idx == last) begin
            bsy   <= 1'b0;
            dn    <= 1'b1;
            state <= DONE;
          end else begin
            idx   <= idx + IM'(1);
            rdy   <= 1'b1;
            state <= RECV;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_loader.sv
module tb_instruction_loader;
  localparam int N = 32, IM = 5, NB = N / 8, DEPTH = 1 << IM;
  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0, errors = 0, cyc = 0;

  instruction_loader_if #(.N(N), .IM(IM)) bus ();
  instruction_loader #(.N(N), .IM(IM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: sampled mid low phase, after inputs driven at negedge settle.
  logic [IM-1:0] wa[$];
  logic [N-1:0]  wd[$];
  int            wt[$];
  always @(negedge clk) begin
    #2;
    if (bus.mem_we === 1'b1) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_wdata);
      wt.push_back(cyc);
    end
  end

  // Reference: a load of c words writes word w = bytes[NB*w .. NB*w+NB-1]
  // (first byte most significant) to address w.
  logic [IM-1:0] ea[$];
  logic [N-1:0]  ed[$];
  task automatic model(input int wcount, input bq_t b);
    int words;
    logic [N-1:0] v;
    words = (wcount == 0 || wcount > DEPTH) ? DEPTH : wcount;
    ea.delete(); ed.delete();
    for (int w = 0; w < words; w++) begin
      v = '0;
      for (int k = 0; k < NB; k++) v = (v << 8) | N'(b[w * NB + k]);
      ea.push_back(w[IM-1:0]);
      ed.push_back(v);
    end
  endtask

  task automatic clr();
    wa.delete(); wd.delete(); wt.delete();
  endtask

  task automatic rand_bytes(input int n, output bq_t b);
    b.delete();
    for (int k = 0; k < n; k++) b.push_back(8'($urandom_range(0, 255)));
  endtask

  // Called at a negedge; returns at the negedge after start was taken.
  task automatic do_start(input int wcount);
    bus.word_count = wcount[IM:0];
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.word_count = '0;
  endtask

  // mode 0: in_valid held high, 1: toggling, 2: random.
  // poke: also raise start (word_count=1) while bytes 2 and 4 are offered.
  task automatic stream(input bq_t b, input int cnt, input int mode, input bit poke);
    int i, n;
    bit v, acc;
    i = 0; n = 0;
    while (i < cnt && n < 2000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (n % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      bus.in_valid = v;
      bus.in_data  = b[i];
      bus.start    = poke && (i == 2 || i == 4);
      bus.word_count = poke ? (IM+1)'(1) : '0;
      acc = v && (bus.in_ready === 1'b1);
      @(negedge clk);
      if (acc) i++;
      n++;
    end
    bus.in_valid = 1'b0;
    bus.start = 1'b0;
    bus.word_count = '0;
    checks++;
    if (i != cnt) begin
      errors++;
      $display("FAIL stream_accept: accepted %0d bytes, required %0d", i, cnt);
    end
  endtask

  task automatic wait_done(output int td);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    td = cyc;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({bus.in_ready, bus.mem_we, bus.busy, bus.done} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 0000", {bus.in_ready, bus.mem_we, bus.busy, bus.done});
    end
    checks++;
    if (bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_bus: addr %h data %h, required 0 0", bus.mem_addr, bus.mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Bytes offered while idle must not be taken.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0 || wa.size() != 0) begin
      errors++;
      $display("FAIL idle_quiet: in_ready %b busy %b writes %0d, required 0 0 0", bus.in_ready, bus.busy, wa.size());
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    bq_t b;
    int t0, td;
    b = '{8'h20, 8'h01, 8'h00, 8'h03, 8'h20, 8'h02, 8'h00, 8'h07};
    clr();
    do_start(2);
    t0 = cyc;
    stream(b, 8, 0, 1'b0);
    wait_done(td);
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_status: done %b busy %b, required 1 0", bus.done, bus.busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wa.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: %0d writes, required 2", wa.size());
    end else begin
      checks++;
      if (wa[0] !== 5'd0 || wd[0] !== 32'h20010003) begin
        errors++;
        $display("FAIL b2b_w0: addr %0d data %h, required 0 20010003", wa[0], wd[0]);
      end
      checks++;
      if (wa[1] !== 5'd1 || wd[1] !== 32'h20020007) begin
        errors++;
        $display("FAIL b2b_w1: addr %0d data %h, required 1 20020007", wa[1], wd[1]);
      end
      checks++;
      if (wt[0] - t0 != NB || wt[1] - wt[0] != NB + 1) begin
        errors++;
        $display("FAIL b2b_timing: first at +%0d, spacing %0d, required +%0d, %0d", wt[0] - t0, wt[1] - wt[0], NB, NB + 1);
      end
      checks++;
      if (td != wt[1] + 1) begin
        errors++;
        $display("FAIL b2b_done_lat: done %0d cycles after last write, required 1", td - wt[1]);
      end
    end
  endtask

  task automatic test_toggle();
    bq_t b;
    int td;
    b = '{8'h20, 8'h01, 8'h00, 8'h03, 8'h20, 8'h02, 8'h00, 8'h07};
    clr();
    do_start(2);
    stream(b, 8, 1, 1'b0);
    wait_done(td);
    repeat (3) @(negedge clk);
    checks++;
    if (wa.size() != 2 || wa[0] !== 5'd0 || wd[0] !== 32'h20010003 || wa[1] !== 5'd1 || wd[1] !== 32'h20020007) begin
      errors++;
      $display("FAIL toggle_writes: %0d writes, first %0d:%h, required 2 writes 0:20010003 1:20020007", wa.size(), wa[0], wd[0]);
    end
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL toggle_done: got %b, required 1", bus.done);
    end
  endtask

  task automatic test_full_depth();
    bq_t b;
    int td, zeros;
    rand_bytes(DEPTH * NB, b);
    model(0, b);
    clr();
    do_start(0);
    stream(b, DEPTH * NB, 0, 1'b0);
    wait_done(td);
    repeat (6) @(negedge clk);
    checks++;
    if (wa.size() != ea.size()) begin
      errors++;
      $display("FAIL full_count: %0d writes, required %0d", wa.size(), ea.size());
    end
    for (int k = 0; k < ea.size() && k < wa.size(); k++) begin
      checks++;
      if (wa[k] !== ea[k] || wd[k] !== ed[k]) begin
        errors++;
        $display("FAIL full_w%0d: %0d:%h, required %0d:%h", k, wa[k], wd[k], ea[k], ed[k]);
      end
    end
    zeros = 0;
    foreach (wa[k]) if (wa[k] == '0) zeros++;
    checks++;
    if (zeros != 1 || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL full_end: addr0 writes %0d done %b, required 1 1", zeros, bus.done);
    end
  endtask

  task automatic test_abort();
    bq_t b;
    int td;
    // Abort in RECV, two bytes into word 1, with a byte offered alongside.
    rand_bytes(2 * NB, b);
    model(2, b);
    clr();
    do_start(2);
    stream(b, NB + 2, 0, 1'b0);
    bus.abort = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = b[NB + 2];
    @(negedge clk);
    bus.abort = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (wa.size() != 1 || wa[0] !== ea[0] || wd[0] !== ed[0]) begin
      errors++;
      $display("FAIL abort_recv_writes: %0d writes, first %0d:%h, required 1 write %0d:%h", wa.size(), wa[0], wd[0], ea[0], ed[0]);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_recv_status: busy %b done %b ready %b, required 0 0 0", bus.busy, bus.done, bus.in_ready);
    end
    // Fresh load after abort restarts at address 0.
    rand_bytes(2 * NB, b);
    model(2, b);
    clr();
    do_start(2);
    stream(b, 2 * NB, 2, 1'b0);
    wait_done(td);
    repeat (3) @(negedge clk);
    checks++;
    if (wa.size() != 2 || wa[0] !== ea[0] || wd[0] !== ed[0] || wa[1] !== ea[1] || wd[1] !== ed[1]) begin
      errors++;
      $display("FAIL abort_reload: %0d writes, first %0d:%h, required 2 writes from %0d:%h", wa.size(), wa[0], wd[0], ea[0], ed[0]);
    end
    // Abort during the WRITE cycle of word 0 suppresses that write.
    clr();
    do_start(2);
    stream(b, NB, 0, 1'b0);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (wa.size() != 0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL abort_write: writes %0d busy %b done %b, required 0 0 0", wa.size(), bus.busy, bus.done);
    end
  endtask

  task automatic test_reset_mid();
    bq_t b;
    rand_bytes(2 * NB, b);
    do_start(2);
    stream(b, NB + 2, 0, 1'b0);
    clr();
    bus.in_valid = 1'b1;
    bus.in_data = b[NB + 2];
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.mem_we, bus.busy, bus.done} !== 4'b0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
      errors++;
      $display("FAIL rstmid_clear: flags %b addr %h data %h, required 0000 0 0",
               {bus.in_ready, bus.mem_we, bus.busy, bus.done}, bus.mem_addr, bus.mem_wdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (wa.size() != 0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after: writes %0d done %b busy %b, required 0 0 0", wa.size(), bus.done, bus.busy);
    end
  endtask

  task automatic test_ignore();
    bq_t b;
    int td;
    rand_bytes(2 * NB, b);
    model(2, b);
    clr();
    do_start(2);
    stream(b, 2 * NB, 0, 1'b1);
    wait_done(td);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (wa.size() != 2 || wa[0] !== ea[0] || wd[0] !== ed[0] || wa[1] !== ea[1] || wd[1] !== ed[1]) begin
      errors++;
      $display("FAIL ignore_writes: %0d writes, last %h, required 2 writes ending %h", wa.size(), wd[wa.size() > 0 ? wa.size() - 1 : 0], ed[1]);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_done: done %b busy %b, required 1 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_random();
    bq_t b;
    int td, wcount, mode;
    for (int it = 0; it < 6; it++) begin
      wcount = (it == 5) ? $urandom_range(DEPTH + 1, 2 * DEPTH - 1) : $urandom_range(1, 5);
      mode = $urandom_range(0, 2);
      rand_bytes(DEPTH * NB, b);
      model(wcount, b);
      clr();
      do_start(wcount);
      stream(b, ea.size() * NB, mode, 1'b0);
      wait_done(td);
      repeat (3) @(negedge clk);
      checks++;
      if (wa.size() != ea.size() || bus.done !== 1'b1) begin
        errors++;
        $display("FAIL rand%0d_count: wc %0d, %0d writes done %b, required %0d writes done 1", it, wcount, wa.size(), bus.done, ea.size());
      end
      for (int k = 0; k < ea.size() && k < wa.size(); k++) begin
        checks++;
        if (wa[k] !== ea[k] || wd[k] !== ed[k]) begin
          errors++;
          $display("FAIL rand%0d_w%0d: %0d:%h, required %0d:%h", it, k, wa[k], wd[k], ea[k], ed[k]);
        end
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.word_count = '0;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    test_reset();
    test_back_to_back();
    test_toggle();
    test_full_depth();
    test_abort();
    test_reset_mid();
    test_ignore();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before finish, required completion");
    $fatal(1);
  end
endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Parameter N, default 32: instruction word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter IM, default 5: instruction memory address width; memory depth is 2**IM words.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle load request.
REQ-006 abort  input  1  synchronous cancel of a load in progress.
REQ-007 word_count  input  IM+1  number of words to load; 0 means 2**IM; sampled when start is accepted.
REQ-008 in_data  input  8  byte stream, MSB byte of each word first.
REQ-009 in_valid  input  1  in_data valid.
REQ-010 in_ready  output  1  loader accepts a byte this cycle.
REQ-011 mem_we  output  1  instruction memory write strobe.
REQ-012 mem_addr  output  IM  write word address.
REQ-013 mem_wdata  output  N  write data.
REQ-014 busy  output  1  load in progress; the processor is held while this is high.
REQ-015 done  output  1  sticky flag: last load completed.

Function
REQ-016 The FSM SHALL have states IDLE, RECV, WRITE and DONE; the reset state SHALL be IDLE.
REQ-017 A byte SHALL be transferred only in a cycle where in_valid=1 and in_ready=1.
REQ-018 in_ready SHALL be 1 only in RECV; in_ready SHALL NOT depend combinationally on in_valid.
REQ-019 In IDLE or DONE, start=1 SHALL latch word_count, clear the word index and byte counter to 0, clear done, and enter RECV next cycle.
REQ-020 start SHALL be ignored in RECV and WRITE.
REQ-021 In RECV, each accepted byte SHALL shift into the assembly register from the LSB side (word = {word[N-9:0], in_data}).
REQ-022 When byte N/8-1 of a word is accepted, the FSM SHALL enter WRITE on the next cycle.
REQ-023 In WRITE, mem_we SHALL be 1 for exactly one cycle, with mem_addr equal to the word index and mem_wdata equal to the assembled word.
REQ-024 mem_we SHALL be 0 in every other state.
REQ-025 After WRITE, if the word index equals the latched count minus 1, the FSM SHALL enter DONE; otherwise it SHALL increment the word index and return to RECV.
REQ-026 When word_count=0, 2**IM words SHALL be written; the index SHALL reach 2**IM-1 and SHALL NOT wrap.
REQ-027 word_count values above 2**IM SHALL be saturated to 2**IM.
REQ-028 busy SHALL be 1 in RECV and WRITE, and 0 in IDLE and DONE.
REQ-029 done SHALL be 1 in DONE, and SHALL stay 1 until the next accepted start or reset.
REQ-030 abort=1 in RECV or WRITE SHALL move the FSM to IDLE next cycle:
- mem_we SHALL be suppressed in that cycle.
- The partial word SHALL be discarded.
- done SHALL remain 0.
- Words already written SHALL be unaffected.
REQ-031 If abort and a byte transfer occur in the same cycle, abort SHALL take priority and the byte SHALL be dropped.
REQ-032 abort SHALL have no effect in IDLE or DONE.
REQ-033 Bytes with in_valid=1 outside RECV SHALL be neither consumed nor stored.
REQ-034 Throughput SHALL be one word per N/8+1 cycles when in_valid is held at 1.

Reset
REQ-035 While rst_n=0, and immediately on assertion regardless of clk, the outputs SHALL be:
- state=IDLE
- in_ready=0, mem_we=0, busy=0, done=0
- mem_addr=0, mem_wdata=0
- internal counters cleared
REQ-036 Reset asserted mid-load SHALL abandon the load with no further memory write; release SHALL resume in IDLE.

Verification
REQ-037 start, word_count=2, with bytes 20 01 00 03 20 02 00 07 streamed back-to-back -> the bench SHALL check:
- mem_we pulses at addr 0 with 0x20010003, then at addr 1 with 0x20020007.
- done=1 and busy=0 one cycle after the second write.
REQ-038 Same stream with in_valid toggling every other cycle -> the same two writes SHALL occur, with no duplicated or lost bytes.
REQ-039 word_count=0 with 128 bytes -> the bench SHALL check:
- 32 writes at addr 0..31.
- done=1.
- no write to addr 0 after addr 31.
REQ-040 abort after 2 bytes of word 1 -> the bench SHALL check:
- no write at addr 1; busy=0 and done=0.
- a subsequent start plus a full stream rewrites from addr 0.
REQ-041 rst_n pulled low mid-word (asynchronously, between clock edges) -> the bench SHALL check:
- outputs clear immediately.
- no mem_we occurs.
- done=0 after release.
REQ-042 start asserted in RECV, and abort asserted in DONE -> both SHALL be ignored, the load SHALL complete unchanged, and done SHALL remain 1.
